tiny_nn_core_ctrl: RTL and testbench
====================================

// Module: tiny_nn_core_ctrl
// PURPOSE
// Sequencer for one tiny_nn_core instance (4x2 value/param array, 2-level adder tree, final accumulator).
// Accepts a neuron command: N chunks of 8 (param, value) pairs, optional ReLU.
// Per chunk: streams params/values into the array, drives the multiply/accumulate schedule, chains chunks via loopback.
// Returns one fp_t result per command over a valid/ready port.
// PARAMETERS
// ChunkCntW       8  width of cmd_chunks_i; a command carries 1..2^ChunkCntW chunks
// ValArrayWidth   4  core array width; any other value is an elaboration error
// ValArrayHeight  2  core array height; any other value is an elaboration error
// PORTS
// clk_i                        in   1   clock
// rst_i                        in   1   reset
// cmd_valid_i / cmd_ready_o    in/out 1 command handshake
// cmd_chunks_i                 in   ChunkCntW  chunk count minus 1
// cmd_relu_i                   in   1   apply ReLU to the final result
// param_valid_i / param_ready_o in/out 1 param stream handshake
// param_data_i                 in   16  fp_t param
// val_valid_i / val_ready_o    in/out 1 value stream handshake
// val_data_i                   in   16  fp_t value
// res_valid_o / res_ready_i    out/in 1 result handshake
// res_data_o                   out  16  fp_t result (= core_acc_i)
// core_val_o, core_param_o     out  16  to core val_i/param_i (= val_data_i/param_data_i)
// core_val_shift_o             out  2   to core val_shift_i
// core_param_write_o           out  8   to core param_write_i
// core_mul_row_sel_o, core_mul_en_o, core_acc_loopback_o, core_acc_relu_o  out 1 each, to core
// core_acc_en_o                out  2   to core accumulate_en_i
// core_l1_direct_din_o / _en_o out  16/2 tied 0
// core_acc_i                   in   16  from core accumulate_o
// BEHAVIOUR
// - One clock. Reset is synchronous and active-high: the clock port is clk_i and the reset port is rst_i.
// - rst_i wins over everything. The next state is IDLE; chunk/param/value counters clear; in-flight work is dropped.
// - While rst_i=1, every output is 0, including cmd_ready_o.
// - All core_* enables are decoded from state and are 0 outside the cycles listed below.
// - States: IDLE, LOAD, E0, E1, E2, E3, E4, RESP.
// - IDLE: cmd_ready_o=1. On handshake: latch chunks and relu, chunk_idx=0, go to LOAD.
// - LOAD: param_ready_o=(pcnt<8), val_ready_o=(vcnt<8). The two streams are independent, one beat each per cycle.
//   - Param beat k: core_param_write_o one-hot bit (k%4)*2+k/4.
//   - Value beat k: core_val_shift_o[k/4]=1. Value k pairs with param k.
//   - pcnt==8 && vcnt==8 -> E0; counters clear.
// - Chunk schedule, one cycle per state. A = chunk_idx==0; B = later chunks.
//   - E0: sel=1, mul_en=1 (row0 products).
//   - E1: sel=0, mul_en=1, acc_en=01.
//   - E2: A: sel=1, acc_en=01, so l1[1] <= row0 sum. B: sel=0, acc_en=01, so l1[0] <= row0 sum.
//   - E3: A: sel=0, acc_en=01, so l1[0] <= row1 sum. B: sel=0, acc_en=11, loopback=1, so final <= row0+prior and l1[0] <= row1.
//   - E4: acc_en=10. A: loopback=0. B: loopback=1. relu = cmd_relu & last chunk.
//   - E4 exit: last chunk -> RESP, otherwise chunk_idx++ and go to LOAD.
// - ReLU is never asserted on intermediate steps, so negative partial sums carry forward.
// - RESP: res_valid_o=1; res_data_o holds stable until res_ready_i, then go to IDLE. A new cmd is accepted no earlier than the next cycle.
// - Latency: last operand beat in cycle t -> E0 at t+1, E4 at t+5, res_valid_o at t+6.
// - Operands for the next chunk are accepted only in LOAD (no overlap with E0-E4).
// - Stream beats presented outside LOAD are not accepted.
// TESTING
// 1. 1 chunk, params 1.0, values 1.0..8.0 -> res 36.0 at t+6.
//    param_write bit order 0,2,4,6,1,3,5,7; val_shift 01 x4 then 10 x4.
// 2. 3 chunks, params 1.0, values 1.0 -> res 24.0. Loopback high only in E3/E4 of chunks 2 and 3.
// 3. 1 chunk, params -1.0, values 1.0: relu=1 -> 0.0, relu=0 -> -8.0.
// 4. 2 chunks with relu=1, chunk sums -8.0 then +10.0 -> 2.0 (no intermediate ReLU).
// 5. Random valid gaps on both streams, res_ready_i low for 10 cycles.
//    Response: no beat lost or duplicated; res_data_o stable; cmd_ready_o=0 until the result handshake.
// 6. rst_i in E2 -> all outputs 0 next cycle, state IDLE. A following 1-chunk command returns the correct 36.0.

Source files
------------

// File: rtl/tiny_nn_core_ctrl.sv
// Sequencer for one tiny_nn_core: loads 8 (param, value) pairs per chunk, runs the
// multiply/adder-tree/accumulate schedule, chains chunks via loopback, returns one result.
module tiny_nn_core_ctrl #(
   parameter int ChunkCntW      = 8,
   parameter int ValArrayWidth  = 4,
   parameter int ValArrayHeight = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [ChunkCntW-1:0] cmd_chunks_i,
   input  logic                 cmd_relu_i,
   input  logic                 param_valid_i,
   output logic                 param_ready_o,
   input  logic [15:0]          param_data_i,
   input  logic                 val_valid_i,
   output logic                 val_ready_o,
   input  logic [15:0]          val_data_i,
   output logic                 res_valid_o,
   input  logic                 res_ready_i,
   output logic [15:0]          res_data_o,
   output logic [15:0]          core_val_o,
   output logic [15:0]          core_param_o,
   output logic [1:0]           core_val_shift_o,
   output logic [7:0]           core_param_write_o,
   output logic                 core_mul_row_sel_o,
   output logic                 core_mul_en_o,
   output logic                 core_acc_loopback_o,
   output logic                 core_acc_relu_o,
   output logic [1:0]           core_acc_en_o,
   output logic [15:0]          core_l1_direct_din_o,
   output logic [1:0]           core_l1_direct_en_o,
   input  logic [15:0]          core_acc_i
);

   if (ValArrayWidth != 4 || ValArrayHeight != 2) begin : g_bad_geometry
      $error("tiny_nn_core_ctrl supports only a 4x2 value array");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_E0, S_E1, S_E2, S_E3, S_E4, S_RESP
   } state_e;

   state_e               state;
   logic [ChunkCntW-1:0] chunks_q;
   logic [ChunkCntW-1:0] chunk_idx;
   logic                 relu_q;
   logic [3:0]           pcnt;
   logic [3:0]           vcnt;
   logic                 p_beat;
   logic                 v_beat;
   logic [3:0]           pcnt_nx;
   logic [3:0]           vcnt_nx;
   logic                 first_chunk;
   logic                 last_chunk;

   assign p_beat      = (state == S_LOAD) && !pcnt[3] && param_valid_i;
   assign v_beat      = (state == S_LOAD) && !vcnt[3] && val_valid_i;
   assign pcnt_nx     = pcnt + {3'b000, p_beat};
   assign vcnt_nx     = vcnt + {3'b000, v_beat};
   assign first_chunk = (chunk_idx == '0);
   assign last_chunk  = (chunk_idx == chunks_q);

   // Outputs decode from registered state; the operand beat strobes must follow the
   // same-cycle handshake, and everything is forced low while rst_i is held.
   always_comb begin
      cmd_ready_o          = 1'b0;
      param_ready_o        = 1'b0;
      val_ready_o          = 1'b0;
      res_valid_o          = 1'b0;
      res_data_o           = '0;
      core_val_o           = '0;
      core_param_o         = '0;
      core_val_shift_o     = '0;
      core_param_write_o   = '0;
      core_mul_row_sel_o   = 1'b0;
      core_mul_en_o        = 1'b0;
      core_acc_loopback_o  = 1'b0;
      core_acc_relu_o      = 1'b0;
      core_acc_en_o        = '0;
      core_l1_direct_din_o = '0;
      core_l1_direct_en_o  = '0;
      if (!rst_i) begin
         core_val_o   = val_data_i;
         core_param_o = param_data_i;
         res_data_o   = core_acc_i;
         case (state)
            S_IDLE: cmd_ready_o = 1'b1;
            S_LOAD: begin
               param_ready_o = !pcnt[3];
               val_ready_o   = !vcnt[3];
               // Param k lands in column k%4, row k/4 of the core's column-major write map.
               if (p_beat) core_param_write_o[{pcnt[1:0], pcnt[2]}] = 1'b1;
               if (v_beat) core_val_shift_o[vcnt[2]] = 1'b1;
            end
            S_E0: begin
               core_mul_row_sel_o = 1'b1;
               core_mul_en_o      = 1'b1;
            end
            S_E1: begin
               core_mul_en_o = 1'b1;
               core_acc_en_o = 2'b01;
            end
            S_E2: begin
               core_mul_row_sel_o = first_chunk;
               core_acc_en_o      = 2'b01;
            end
            S_E3: begin
               core_acc_en_o       = first_chunk ? 2'b01 : 2'b11;
               core_acc_loopback_o = !first_chunk;
            end
            S_E4: begin
               core_acc_en_o       = 2'b10;
               core_acc_loopback_o = !first_chunk;
               core_acc_relu_o     = relu_q && last_chunk;
            end
            S_RESP: res_valid_o = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= S_IDLE;
         chunks_q  <= '0;
         chunk_idx <= '0;
         relu_q    <= 1'b0;
         pcnt      <= '0;
         vcnt      <= '0;
      end else begin
         case (state)
            S_IDLE: if (cmd_valid_i) begin
               chunks_q  <= cmd_chunks_i;
               relu_q    <= cmd_relu_i;
               chunk_idx <= '0;
               state     <= S_LOAD;
            end
            S_LOAD: begin
               if (pcnt_nx == 4'd8 && vcnt_nx == 4'd8) begin
                  pcnt  <= '0;
                  vcnt  <= '0;
                  state <= S_E0;
               end else begin
                  pcnt <= pcnt_nx;
                  vcnt <= vcnt_nx;
               end
            end
            S_E0: state <= S_E1;
            S_E1: state <= S_E2;
            S_E2: state <= S_E3;
            S_E3: state <= S_E4;
            S_E4: begin
               if (last_chunk) begin
                  state <= S_RESP;
               end else begin
                  chunk_idx <= chunk_idx + 1'b1;
                  state     <= S_LOAD;
               end
            end
            S_RESP: if (res_ready_i) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tiny_nn_core_ctrl.sv
// Directed bench for tiny_nn_core_ctrl with a behavioural core model; data is treated
// as Q8.8 fixed point by the model (the controller never interprets operand bits).
module tb_tiny_nn_core_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic [7:0]  cmd_chunks_i = '0;
   logic        cmd_relu_i = 1'b0;
   logic        param_valid_i = 1'b0;
   logic        param_ready_o;
   logic [15:0] param_data_i = '0;
   logic        val_valid_i = 1'b0;
   logic        val_ready_o;
   logic [15:0] val_data_i = '0;
   logic        res_valid_o;
   logic        res_ready_i = 1'b0;
   logic [15:0] res_data_o;
   logic [15:0] core_val_o, core_param_o;
   logic [1:0]  core_val_shift_o;
   logic [7:0]  core_param_write_o;
   logic        core_mul_row_sel_o, core_mul_en_o, core_acc_loopback_o, core_acc_relu_o;
   logic [1:0]  core_acc_en_o;
   logic [15:0] core_l1_direct_din_o;
   logic [1:0]  core_l1_direct_en_o;
   logic [15:0] core_acc_i;

   tiny_nn_core_ctrl #(.ChunkCntW(8), .ValArrayWidth(4), .ValArrayHeight(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_chunks_i(cmd_chunks_i), .cmd_relu_i(cmd_relu_i),
      .param_valid_i(param_valid_i), .param_ready_o(param_ready_o), .param_data_i(param_data_i),
      .val_valid_i(val_valid_i), .val_ready_o(val_ready_o), .val_data_i(val_data_i),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
      .core_val_o(core_val_o), .core_param_o(core_param_o),
      .core_val_shift_o(core_val_shift_o), .core_param_write_o(core_param_write_o),
      .core_mul_row_sel_o(core_mul_row_sel_o), .core_mul_en_o(core_mul_en_o),
      .core_acc_loopback_o(core_acc_loopback_o), .core_acc_relu_o(core_acc_relu_o),
      .core_acc_en_o(core_acc_en_o),
      .core_l1_direct_din_o(core_l1_direct_din_o), .core_l1_direct_en_o(core_l1_direct_en_o),
      .core_acc_i(core_acc_i)
   );

   always #5 clk_i = ~clk_i;

   logic [85:0] all_out;
   assign all_out = {cmd_ready_o, param_ready_o, val_ready_o, res_valid_o, res_data_o,
                     core_val_o, core_param_o, core_val_shift_o, core_param_write_o,
                     core_mul_row_sel_o, core_mul_en_o, core_acc_loopback_o, core_acc_relu_o,
                     core_acc_en_o, core_l1_direct_din_o, core_l1_direct_en_o};

   // Core model: row shift registers, param cells, product regs, one sum stage, l1 pair, final.
   logic signed [15:0] mval [2][4] = '{default: '0};
   logic signed [15:0] mpar [2][4] = '{default: '0};
   logic signed [15:0] mprod [4]   = '{default: '0};
   logic signed [15:0] ml1 [2]     = '{default: '0};
   logic signed [15:0] ms          = '0;
   logic signed [15:0] mfinal      = '0;

   function automatic logic signed [15:0] qmul(input logic signed [15:0] a, input logic signed [15:0] b);
      logic signed [31:0] p;
      p = a * b;
      return p[23:8];
   endfunction

   always @(posedge clk_i) begin
      logic signed [15:0] nf;
      for (int r = 0; r < 2; r++) begin
         if (core_val_shift_o[r]) begin
            for (int j = 0; j < 3; j++) mval[r][j] <= mval[r][j+1];
            mval[r][3] <= core_val_o;
         end
      end
      for (int b = 0; b < 8; b++)
         if (core_param_write_o[b]) mpar[b % 2][b / 2] <= core_param_o;
      if (core_mul_en_o)
         for (int j = 0; j < 4; j++)
            mprod[j] <= qmul(mval[core_mul_row_sel_o ? 0 : 1][j], mpar[core_mul_row_sel_o ? 0 : 1][j]);
      if (core_acc_en_o[0]) begin
         ms <= mprod[0] + mprod[1] + mprod[2] + mprod[3];
         ml1[core_mul_row_sel_o ? 1 : 0] <= ms;
      end
      if (core_acc_en_o[1]) begin
         nf = core_acc_loopback_o ? ml1[0] + mfinal : ml1[0] + ml1[1];
         mfinal <= (core_acc_relu_o && nf < 0) ? 16'sd0 : nf;
      end
   end
   assign core_acc_i = mfinal;

   int cyc = 0;
   int lb_cnt = 0;
   int relu_cnt = 0;
   always @(posedge clk_i) cyc <= cyc + 1;
   always @(negedge clk_i) begin
      if (core_acc_loopback_o) lb_cnt <= lb_cnt + 1;
      if (core_acc_relu_o) relu_cnt <= relu_cnt + 1;
   end

   int checks = 0;
   int errors = 0;
   int pbit [8] = '{0, 2, 4, 6, 1, 3, 5, 7};

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input logic [7:0] n_minus1, input logic relu);
      @(negedge clk_i);
      cmd_valid_i  = 1'b1;
      cmd_chunks_i = n_minus1;
      cmd_relu_i   = relu;
      #1 check("cmd_ready_idle", cmd_ready_o, 1);
      @(posedge clk_i);
      #1 cmd_valid_i = 1'b0;
   endtask

   task automatic load_chunk(input logic [15:0] p[8], input logic [15:0] v[8], input bit gaps,
                             output int last_cyc);
      int pi, vi, guard;
      logic pacc, vacc;
      pi = 0; vi = 0; guard = 0; last_cyc = -1;
      while ((pi < 8 || vi < 8) && guard < 200) begin
         @(negedge clk_i);
         param_valid_i = (pi < 8) && (!gaps || $urandom_range(0, 2) != 0);
         val_valid_i   = (vi < 8) && (!gaps || $urandom_range(0, 2) != 0);
         param_data_i  = (pi < 8) ? p[pi] : 16'h0;
         val_data_i    = (vi < 8) ? v[vi] : 16'h0;
         #1;
         pacc = param_valid_i && param_ready_o;
         vacc = val_valid_i && val_ready_o;
         if (pacc) check("param_write", core_param_write_o, 8'd1 << pbit[pi]);
         if (vacc) check("val_shift", core_val_shift_o, (vi < 4) ? 2'b01 : 2'b10);
         if (pacc || vacc) last_cyc = cyc;
         @(posedge clk_i);
         if (pacc) pi++;
         if (vacc) vi++;
         guard++;
      end
      #1;
      param_valid_i = 1'b0;
      val_valid_i   = 1'b0;
      check("load_all_beats", {pi[7:0], vi[7:0]}, {8'd8, 8'd8});
   endtask

   task automatic wait_result(input logic [15:0] exp, input int last_cyc, input int hold);
      int n;
      logic got;
      logic [15:0] held;
      n = 0; got = 1'b0;
      param_valid_i = 1'b1;
      val_valid_i   = 1'b1;
      while (!got && n < 50) begin
         @(negedge clk_i);
         #1;
         if (res_valid_o) got = 1'b1;
         else begin
            check("no_beats_outside_load", {param_ready_o, val_ready_o, core_param_write_o, core_val_shift_o}, 0);
            n++;
         end
      end
      param_valid_i = 1'b0;
      val_valid_i   = 1'b0;
      check("res_valid_seen", got, 1);
      check("latency", cyc - last_cyc, 6);
      check("res_data", res_data_o, exp);
      held = res_data_o;
      repeat (hold) begin
         @(negedge clk_i);
         #1;
         check("res_hold", {res_valid_o, cmd_ready_o, res_data_o}, {1'b1, 1'b0, held});
      end
      @(negedge clk_i);
      res_ready_i = 1'b1;
      @(posedge clk_i);
      #1 res_ready_i = 1'b0;
      @(negedge clk_i);
      check("idle_after_resp", {res_valid_o, cmd_ready_o}, 2'b01);
   endtask

   logic [15:0] ones[8], seq[8], neg[8], halves[8], mix[8];
   int lc, lb0, rl0;

   initial begin
      for (int k = 0; k < 8; k++) begin
         ones[k]   = 16'h0100;
         seq[k]    = 16'((k + 1) * 256);
         neg[k]    = 16'hFF00;
         halves[k] = 16'h0080;
         mix[k]    = (k < 6) ? 16'h0100 : 16'h0200;
      end

      // Reset with live-looking inputs: every output must stay low.
      val_data_i = 16'hA5A5; param_data_i = 16'h5A5A; param_valid_i = 1'b1;
      val_valid_i = 1'b1; cmd_valid_i = 1'b1; res_ready_i = 1'b1;
      repeat (3) @(negedge clk_i);
      check("reset_outputs", all_out, 0);
      param_valid_i = 1'b0; val_valid_i = 1'b0; cmd_valid_i = 1'b0; res_ready_i = 1'b0;
      rst_i = 1'b0;
      #1 check("idle_after_reset", {cmd_ready_o, param_ready_o, val_ready_o, res_valid_o}, 4'b1000);

      // 1 chunk: params 1.0, values 1..8 -> 36.0
      lb0 = lb_cnt; rl0 = relu_cnt;
      send_cmd(8'd0, 1'b0);
      load_chunk(ones, seq, 1'b0, lc);
      wait_result(16'h2400, lc, 2);
      check("t1_loopback_cycles", lb_cnt - lb0, 0);
      check("t1_relu_cycles", relu_cnt - rl0, 0);

      // 3 chunks of 8 x (1.0*1.0) -> 24.0
      lb0 = lb_cnt;
      send_cmd(8'd2, 1'b0);
      for (int c = 0; c < 3; c++) load_chunk(ones, ones, 1'b0, lc);
      wait_result(16'h1800, lc, 0);
      check("t2_loopback_cycles", lb_cnt - lb0, 4);

      // Negative sum with and without ReLU
      rl0 = relu_cnt;
      send_cmd(8'd0, 1'b1);
      load_chunk(neg, ones, 1'b0, lc);
      wait_result(16'h0000, lc, 0);
      check("t3_relu_cycles", relu_cnt - rl0, 1);
      send_cmd(8'd0, 1'b0);
      load_chunk(neg, ones, 1'b0, lc);
      wait_result(16'hF800, lc, 0);

      // -8.0 then +10.0 with ReLU only at the end -> 2.0
      lb0 = lb_cnt; rl0 = relu_cnt;
      send_cmd(8'd1, 1'b1);
      load_chunk(neg, ones, 1'b0, lc);
      load_chunk(ones, mix, 1'b0, lc);
      wait_result(16'h0200, lc, 0);
      check("t4_loopback_cycles", lb_cnt - lb0, 2);
      check("t4_relu_cycles", relu_cnt - rl0, 1);

      // Random stream gaps, result held for 10 cycles: 2 x (0.5 * 1..8) -> 36.0
      send_cmd(8'd1, 1'b0);
      load_chunk(halves, seq, 1'b1, lc);
      load_chunk(halves, seq, 1'b1, lc);
      wait_result(16'h2400, lc, 10);

      // Reset asserted in E2 of a 1-chunk command
      send_cmd(8'd0, 1'b0);
      load_chunk(ones, seq, 1'b0, lc);
      repeat (3) @(negedge clk_i);
      check("in_e2", {core_acc_en_o, core_mul_row_sel_o, core_mul_en_o}, 4'b0110);
      rst_i = 1'b1;
      #1 check("reset_mid_outputs", all_out, 0);
      @(negedge clk_i);
      check("reset_hold_outputs", all_out, 0);
      rst_i = 1'b0;
      #1 check("idle_after_mid_reset", {cmd_ready_o, res_valid_o, core_acc_en_o}, 4'b1000);
      lb0 = lb_cnt;
      send_cmd(8'd0, 1'b0);
      load_chunk(ones, seq, 1'b0, lc);
      wait_result(16'h2400, lc, 0);
      check("t6_loopback_cycles", lb_cnt - lb0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
